// File: rtl/phys_freelist_if.sv
// Rename-stage handshake for the physical register free list:
// allocation grant/offer, release ports, commit count and squash.
interface phys_freelist_if #(
  parameter int NUM_PR    = 64,
  parameter int ALLOC_W   = 2,
  parameter int DEALLOC_W = 2
);
  localparam int PR_W  = $clog2(NUM_PR);
  localparam int PTR_W = PR_W + 1;
  localparam int CMT_W = $clog2(ALLOC_W) + 1;

  logic [ALLOC_W-1:0]              i_alloc_req;
  logic                            o_alloc_rdy;
  logic [ALLOC_W-1:0][PR_W-1:0]    o_alloc_prIdx;
  logic [DEALLOC_W-1:0]            i_dealloc_req;
  logic [DEALLOC_W-1:0][PR_W-1:0]  i_dealloc_prIdx;
  logic [CMT_W-1:0]                i_commit_num;
  logic                            i_squash;
  logic [PTR_W-1:0]                o_free_count;

  modport master (
    output i_alloc_req, i_dealloc_req, i_dealloc_prIdx, i_commit_num, i_squash,
    input  o_alloc_rdy, o_alloc_prIdx, o_free_count
  );

  modport slave (
    input  i_alloc_req, i_dealloc_req, i_dealloc_prIdx, i_commit_num, i_squash,
    output o_alloc_rdy, o_alloc_prIdx, o_free_count
  );
endinterface

// File: rtl/phys_freelist.sv
// Circular free list of physical registers with speculative and committed
// read heads; squash rewinds the speculative head to the committed one.
module phys_freelist #(
  parameter int NUM_PR    = 64,
  parameter int NUM_AR    = 32,
  parameter int ALLOC_W   = 2,
  parameter int DEALLOC_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  phys_freelist_if.slave bus
);
  localparam int PR_W  = $clog2(NUM_PR);
  localparam int PTR_W = PR_W + 1;

  logic [PR_W-1:0]                 r_entry [NUM_PR];
  logic [PTR_W-1:0]                r_spec_head;
  logic [PTR_W-1:0]                r_commit_head;
  logic [PTR_W-1:0]                r_tail;

  logic [PTR_W-1:0]                w_free_count;
  logic                            w_alloc_rdy;
  logic [PTR_W-1:0]                w_alloc_cnt;
  logic [PTR_W-1:0]                w_dealloc_cnt;
  logic [PTR_W-1:0]                w_commit_nxt;
  logic [ALLOC_W-1:0][PTR_W-1:0]   w_rd_ptr;
  logic [DEALLOC_W-1:0][PTR_W-1:0] w_wr_ptr;

  assign w_free_count = r_tail - r_spec_head;
  assign w_alloc_rdy  = (w_free_count >= PTR_W'(ALLOC_W));
  assign w_commit_nxt = r_commit_head + PTR_W'(bus.i_commit_num);

  assign bus.o_free_count = w_free_count;
  assign bus.o_alloc_rdy  = w_alloc_rdy;

  always_comb begin
    w_rd_ptr = '0;
    bus.o_alloc_prIdx = '0;
    w_alloc_cnt = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      w_rd_ptr[k] = r_spec_head + PTR_W'(k);
      bus.o_alloc_prIdx[k] = r_entry[w_rd_ptr[k][PR_W-1:0]];
      w_alloc_cnt = w_alloc_cnt + PTR_W'(bus.i_alloc_req[k]);
    end
  end

  // Releases are compacted: each valid port lands after the valid ports below it.
  always_comb begin
    w_wr_ptr = '0;
    w_dealloc_cnt = '0;
    for (int p = 0; p < DEALLOC_W; p++) begin
      w_wr_ptr[p] = r_tail + w_dealloc_cnt;
      w_dealloc_cnt = w_dealloc_cnt + PTR_W'(bus.i_dealloc_req[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_spec_head   <= '0;
      r_commit_head <= '0;
      r_tail        <= PTR_W'(NUM_PR - NUM_AR);
      for (int i = 0; i < NUM_PR; i++)
        r_entry[i] <= (i < NUM_PR - NUM_AR) ? PR_W'(NUM_AR + i) : '0;
    end else begin
      r_commit_head <= w_commit_nxt;
      if (bus.i_squash)
        r_spec_head <= w_commit_nxt;
      else if (w_alloc_rdy)
        r_spec_head <= r_spec_head + w_alloc_cnt;
      r_tail <= r_tail + w_dealloc_cnt;
      for (int p = 0; p < DEALLOC_W; p++)
        if (bus.i_dealloc_req[p])
          r_entry[w_wr_ptr[p][PR_W-1:0]] <= bus.i_dealloc_prIdx[p];
    end
  end

  // Usage rules the rename stage must honour; behaviour is undefined otherwise.
  a_alloc_packed: assert property (@(posedge clk) disable iff (rst)
    ((bus.i_alloc_req & (bus.i_alloc_req + ALLOC_W'(1))) == '0));
  a_free_bound: assert property (@(posedge clk) disable iff (rst)
    (w_free_count <= PTR_W'(NUM_PR)));
  a_commit_order: assert property (@(posedge clk) disable iff (rst)
    ((r_spec_head - r_commit_head) <= PTR_W'(NUM_PR)));
endmodule

// File: tb/tb_phys_freelist.sv
// Bench for phys_freelist: directed corner cases then random traffic, all
// compared against a queue model of the free list.
module tb_phys_freelist;
  localparam int NUM_PR = 64, NUM_AR = 32, ALLOC_W = 2, DEALLOC_W = 2;
  localparam int PR_W = $clog2(NUM_PR);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;

  // Model: fl holds every buffered PR from the oldest uncommitted allocation
  // onward; the first spec entries are speculatively handed out.
  int fl[$];
  int owned[$];
  int spec;

  phys_freelist_if #(.NUM_PR(NUM_PR), .ALLOC_W(ALLOC_W), .DEALLOC_W(DEALLOC_W)) bus ();

  phys_freelist #(.NUM_PR(NUM_PR), .NUM_AR(NUM_AR), .ALLOC_W(ALLOC_W), .DEALLOC_W(DEALLOC_W))
    u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    fl.delete();
    owned.delete();
    spec = 0;
    for (int i = 0; i < NUM_AR; i++) owned.push_back(i);
    for (int i = NUM_AR; i < NUM_PR; i++) fl.push_back(i);
  endtask

  task automatic model_release(input int p);
    for (int i = 0; i < owned.size(); i++)
      if (owned[i] == p) begin
        owned.delete(i);
        break;
      end
    fl.push_back(p);
  endtask

  task automatic check_outputs(input string tag);
    int fc;
    fc = fl.size() - spec;
    chk($sformatf("%s free_count", tag), int'(bus.o_free_count), fc);
    chk($sformatf("%s alloc_rdy", tag), int'(bus.o_alloc_rdy), (fc >= ALLOC_W) ? 1 : 0);
    for (int k = 0; k < ALLOC_W; k++)
      if (k < fc) chk($sformatf("%s prIdx%0d", tag, k), int'(bus.o_alloc_prIdx[k]), fl[spec + k]);
  endtask

  task automatic step(input logic [1:0] a, input logic [1:0] d, input int p0, input int p1,
                      input int c, input bit sq, input string tag);
    int fc, g;
    bus.i_alloc_req        = a;
    bus.i_dealloc_req      = d;
    bus.i_dealloc_prIdx[0] = PR_W'(p0);
    bus.i_dealloc_prIdx[1] = PR_W'(p1);
    bus.i_commit_num       = 2'(c);
    bus.i_squash           = sq;
    fc = fl.size() - spec;
    g = (fc >= ALLOC_W && !sq) ? $countones(a) : 0;
    for (int i = 0; i < c; i++) owned.push_back(fl.pop_front());
    spec = sq ? 0 : spec + g - c;
    if (d[0]) model_release(p0);
    if (d[1]) model_release(p1);
    @(posedge clk);
    #1;
    bus.i_alloc_req   = '0;
    bus.i_dealloc_req = '0;
    bus.i_commit_num  = '0;
    bus.i_squash      = 1'b0;
    check_outputs(tag);
  endtask

  task automatic junk_reset(input int cycles, input string tag);
    bus.i_alloc_req        = 2'b11;
    bus.i_dealloc_req      = 2'b11;
    bus.i_dealloc_prIdx[0] = PR_W'(1);
    bus.i_dealloc_prIdx[1] = PR_W'(2);
    bus.i_commit_num       = 2'd2;
    bus.i_squash           = 1'b1;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_alloc_req   = '0;
    bus.i_dealloc_req = '0;
    bus.i_commit_num  = '0;
    bus.i_squash      = 1'b0;
    model_reset();
    chk($sformatf("%s free_count", tag), int'(bus.o_free_count), 32);
    chk($sformatf("%s alloc_rdy", tag), int'(bus.o_alloc_rdy), 1);
    chk($sformatf("%s prIdx0", tag), int'(bus.o_alloc_prIdx[0]), 32);
    chk($sformatf("%s prIdx1", tag), int'(bus.o_alloc_prIdx[1]), 33);
  endtask

  initial begin
    junk_reset(3, "reset");

    // Speculative allocations are discarded by squash.
    step(2'b11, 2'b00, 0, 0, 0, 1'b0, "alloc2");
    step(2'b00, 2'b00, 0, 0, 0, 1'b1, "squash");
    chk("squash free", int'(bus.o_free_count), 32);
    chk("squash pr0", int'(bus.o_alloc_prIdx[0]), 32);
    chk("squash pr1", int'(bus.o_alloc_prIdx[1]), 33);

    // Drain the list completely.
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        chk("last grant0", int'(bus.o_alloc_prIdx[0]), 62);
        chk("last grant1", int'(bus.o_alloc_prIdx[1]), 63);
      end
      step(2'b11, 2'b00, 0, 0, 2, 1'b0, "drain");
    end
    chk("empty free", int'(bus.o_free_count), 0);
    chk("empty rdy", int'(bus.o_alloc_rdy), 0);
    step(2'b11, 2'b00, 0, 0, 0, 1'b0, "ignored");
    chk("ignored free", int'(bus.o_free_count), 0);

    // Refill from empty, including a sparse release on port 1 only.
    step(2'b00, 2'b11, 5, 7, 0, 1'b0, "rel57");
    chk("rel57 free", int'(bus.o_free_count), 2);
    chk("rel57 rdy", int'(bus.o_alloc_rdy), 1);
    chk("rel57 pr0", int'(bus.o_alloc_prIdx[0]), 5);
    chk("rel57 pr1", int'(bus.o_alloc_prIdx[1]), 7);
    step(2'b00, 2'b10, 3, 9, 0, 1'b0, "rel9");
    chk("rel9 free", int'(bus.o_free_count), 3);
    step(2'b11, 2'b00, 0, 0, 2, 1'b0, "take57");
    chk("take57 free", int'(bus.o_free_count), 1);
    chk("take57 rdy", int'(bus.o_alloc_rdy), 0);
    chk("take57 pr0", int'(bus.o_alloc_prIdx[0]), 9);
    step(2'b00, 2'b01, 11, 0, 0, 1'b0, "rel11");
    chk("rel11 pr0", int'(bus.o_alloc_prIdx[0]), 9);
    chk("rel11 pr1", int'(bus.o_alloc_prIdx[1]), 11);
    step(2'b11, 2'b00, 0, 0, 2, 1'b0, "take911");

    // Random traffic well past several pointer wraps.
    for (int n = 0; n < 1000; n++) begin
      logic [1:0] a, d;
      int p0, p1, c, cmax, fc, g, i0, i1;
      bit sq;
      case ($urandom_range(0, 3))
        0: a = 2'b00;
        1: a = 2'b01;
        default: a = 2'b11;
      endcase
      sq = ($urandom_range(0, 15) == 0);
      fc = fl.size() - spec;
      g = (fc >= ALLOC_W && !sq) ? $countones(a) : 0;
      cmax = spec + g;
      if (cmax > 2) cmax = 2;
      c = $urandom_range(0, cmax);
      d = 2'($urandom_range(0, 3));
      p0 = 0;
      p1 = 0;
      i0 = 0;
      if (owned.size() == 0) d = 2'b00;
      if (owned.size() < 2 && d == 2'b11) d = 2'b01;
      if (d != 2'b00) begin
        i0 = $urandom_range(0, owned.size() - 1);
        p0 = owned[i0];
        p1 = owned[i0];
        if (d == 2'b11) begin
          i1 = (i0 + 1 + $urandom_range(0, owned.size() - 2)) % owned.size();
          p1 = owned[i1];
        end
      end
      step(a, d, p0, p1, c, sq, "rnd");
    end

    junk_reset(1, "rereset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/phys_freelist.md
PHYS_FREELIST -- requirements
Module: phys_freelist

Interface
REQ-001 SHALL have parameter NUM_PR, default 64, meaning physical register count (power of 2).
REQ-002 SHALL have parameter NUM_AR, default 32, meaning architectural registers (PR 0..NUM_AR-1 mapped at reset, not free).
REQ-003 SHALL have parameter ALLOC_W, default 2, meaning rename allocation slots per cycle.
REQ-004 SHALL have parameter DEALLOC_W, default 2, meaning release ports per cycle; each port is driven by the refcount stage's real-dealloc output.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port i_alloc_req  in  ALLOC_W  per-slot allocation request, packed from slot 0.
REQ-008 SHALL have port o_alloc_rdy  out  1  high when free count >= ALLOC_W.
REQ-009 SHALL have port o_alloc_prIdx  out  ALLOC_W x log2(NUM_PR)  PR offered to each slot.
REQ-010 SHALL have port i_dealloc_req  in  DEALLOC_W  per-port release valid, may be sparse.
REQ-011 SHALL have port i_dealloc_prIdx  in  DEALLOC_W x log2(NUM_PR)  released PR per port.
REQ-012 SHALL have port i_commit_num  in  log2(ALLOC_W)+1  allocations retired this cycle.
REQ-013 SHALL have port i_squash  in  1  pipeline flush; discard uncommitted allocations.
REQ-014 SHALL have port o_free_count  out  log2(NUM_PR)+1  free entries (tail - spec_head).

Function
REQ-015 SHALL store free PRs in a NUM_PR-entry circular buffer with pointers spec_head, commit_head, tail, each log2(NUM_PR)+1 bits (wrap bit).
REQ-016 SHALL drive o_alloc_prIdx[k] combinationally = entry[spec_head+k], k < ALLOC_W, index mod NUM_PR.
REQ-017 SHALL perform an allocation only when o_alloc_rdy && !i_squash; spec_head advances by popcount(i_alloc_req) at the clock edge.
REQ-018 SHALL ignore i_alloc_req when o_alloc_rdy is low (all-or-nothing; no partial grant).
REQ-019 SHALL write released PRs at tail in ascending port order, compacted: valid port p goes to entry[tail + number of valid ports below p]; tail advances by popcount(i_dealloc_req).
REQ-020 SHALL make released PRs visible to o_alloc_prIdx / o_free_count from the next cycle only (no same-cycle bypass).
REQ-021 SHALL advance commit_head by i_commit_num each cycle, squash or not.
REQ-022 SHALL on i_squash set spec_head to commit_head + i_commit_num (post-commit value); dealloc in the same cycle still applies.
REQ-023 SHALL compute o_free_count = tail - spec_head and o_alloc_rdy = (o_free_count >= ALLOC_W), both from registered state.
REQ-024 SHALL wrap all pointer arithmetic modulo 2*NUM_PR; entry index = pointer low log2(NUM_PR) bits.
REQ-025 SHALL flag (simulation assertion) non-packed i_alloc_req, free count exceeding NUM_PR, and commit_head passing spec_head; RTL behaviour on these is undefined.

Reset
REQ-026 SHALL on rst set spec_head=0, commit_head=0, tail=NUM_PR-NUM_AR, entry[i]=NUM_AR+i for i < NUM_PR-NUM_AR.
REQ-027 SHALL give, the cycle after rst deasserts, o_free_count=NUM_PR-NUM_AR (32), o_alloc_rdy=1, o_alloc_prIdx={32,33}.
REQ-028 SHALL let rst override squash, alloc, dealloc and commit in the same cycle, discarding all in-flight state.

Verification
REQ-029 SHALL verify: reset, idle -> o_free_count=32, o_alloc_rdy=1, prIdx slots = 32,33.
REQ-030 SHALL verify: req=2'b11 and commit_num=2 every cycle for 16 cycles -> last grant 62,63; then o_free_count=0, o_alloc_rdy=0; further requests are ignored.
REQ-031 SHALL verify: from empty, dealloc ports 0/1 = PR 5/7 -> next cycle o_free_count=2, rdy=1, prIdx = 5,7.
REQ-032 SHALL verify: 2 allocations (32,33) with commit_num=0, then i_squash -> next cycle o_free_count=32 and prIdx again 32,33.
REQ-033 SHALL verify: i_dealloc_req=2'b10 with port1 PR=9 -> single entry written at tail, tail+1, and PR 9 is allocated in FIFO order.
REQ-034 SHALL verify wrap-around: more than 2*NUM_PR cumulative alloc/dealloc cycles -> free count stays exact and no PR is issued twice without an intervening release.
